regfile_write_queue: RTL

REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

---
 rtl/regfile_write_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_write_queue.sv
// Register-write queue: buffers producer writes and drains them in order to the register file.
// Latency: two clock edges from push to rf_we (one edge into the FIFO, one into the output stage).
// Backpressure: in_ready drops when the FIFO is full; drain_en throttles the drain side.
module regfile_write_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [3:0]       in_dest,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             drain_en,
   input  logic             flush,
   output logic             rf_we,
   output logic [3:0]       rf_dest,
   output logic [WIDTH-1:0] rf_data,
   input  logic [3:0]       q_src0,
   input  logic [3:0]       q_src1,
   output logic             q_pend0,
   output logic             q_pend1,
   output logic [WIDTH-1:0] q_data0,
   output logic [WIDTH-1:0] q_data1,
   output logic [3:0]       count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [3:0]       dest;
      logic [WIDTH-1:0] data;
   } wr_ent_t;

   wr_ent_t          mem_q [DEPTH];
   wr_ent_t          mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [3:0]       count_q, count_d;
   logic             rf_we_q, rf_we_d;
   logic [3:0]       rf_dest_q, rf_dest_d;
   logic [WIDTH-1:0] rf_data_q, rf_data_d;
   logic             push, pop;

   // Ready depends on occupancy only; a same-cycle pop never frees room for a push.
   assign in_ready = (count_q < 4'(DEPTH));
   assign push     = in_valid & in_ready & ~flush;
   assign pop      = drain_en & (count_q != 4'd0) & ~flush;

   assign rf_we   = rf_we_q;
   assign rf_dest = rf_dest_q;
   assign rf_data = rf_data_q;
   assign count   = count_q;

   // Next-state: flush wins over push/pop; output stage loads on pop, otherwise holds data.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rf_we_d   = 1'b0;
      rf_dest_d = rf_dest_q;
      rf_data_d = rf_data_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = '{dest: in_dest, data: in_data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            rf_we_d   = 1'b1;
            rf_dest_d = mem_q[rd_ptr_q].dest;
            rf_data_d = mem_q[rd_ptr_q].data;
         end
         count_d = count_q + 4'(push) - 4'(pop);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rf_we_q   <= 1'b0;
         rf_dest_q <= '0;
         rf_data_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rf_we_q   <= rf_we_d;
         rf_dest_q <= rf_dest_d;
         rf_data_q <= rf_data_d;
      end
   end

   // Forwarding lookup: scan output stage first, then FIFO oldest to youngest so the youngest match wins.
   always_comb begin
      q_pend0 = 1'b0;
      q_pend1 = 1'b0;
      q_data0 = '0;
      q_data1 = '0;
      if (rf_we_q && (rf_dest_q == q_src0)) begin
         q_pend0 = 1'b1;
         q_data0 = rf_data_q;
      end
      if (rf_we_q && (rf_dest_q == q_src1)) begin
         q_pend1 = 1'b1;
         q_data1 = rf_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (4'(i) < count_q) begin
            if (mem_q[PW'(rd_ptr_q + PW'(i))].dest == q_src0) begin
               q_pend0 = 1'b1;
               q_data0 = mem_q[PW'(rd_ptr_q + PW'(i))].data;
            end
            if (mem_q[PW'(rd_ptr_q + PW'(i))].dest == q_src1) begin
               q_pend1 = 1'b1;
               q_data1 = mem_q[PW'(rd_ptr_q + PW'(i))].data;
            end
         end
      end
   end

endmodule
